// File: rtl/mdu_ctrl_if.sv
// MDU issue/read bundle between the E stage (master) and the HI/LO controller (slave).
interface mdu_ctrl_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        d_md_use;
   logic        rd_sel;
   logic [31:0] rd_data;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, d_md_use, rd_sel,
      input  rd_data, busy, stall, hi, lo
   );

   modport slave (
      input  start, op, a, b, d_md_use, rd_sel,
      output rd_data, busy, stall, hi, lo
   );
endinterface

// File: rtl/mdu_ctrl.sv
// HI/LO owner for the MIPS E stage: results are computed at issue, held pending, and
// committed when the busy countdown (MULT_CYCLES/DIV_CYCLES) expires; mthi/mtlo write at once.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic       clk,
   input logic       reset,
   mdu_ctrl_if.slave md
);
   localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    hi_q, hi_d, lo_q, lo_d;
   logic [31:0]    phi_q, phi_d, plo_q, plo_d;
   logic           skip_q, skip_d;

   logic [63:0]        prod_s, prod_u;
   logic signed [31:0] quo_s, rem_s;
   logic [31:0]        quo_u, rem_u;
   logic               busy;

   always_comb begin
      prod_s = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};
      prod_u = {32'b0, md.a} * {32'b0, md.b};
      quo_s  = '0;
      rem_s  = '0;
      quo_u  = '0;
      rem_u  = '0;
      // Zero divisor is guarded here; the commit is suppressed via skip_q instead.
      if (md.b != 32'd0) begin
         quo_s = $signed(md.a) / $signed(md.b);
         rem_s = $signed(md.a) % $signed(md.b);
         quo_u = md.a / md.b;
         rem_u = md.a % md.b;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      skip_d  = skip_q;
      unique case (state_q)
         IDLE: begin
            if (md.start) begin
               case (md.op)
                  3'b001: begin
                     phi_d = prod_s[63:32]; plo_d = prod_s[31:0];
                     skip_d = 1'b0; cnt_d = MULT_N; state_d = BUSY;
                  end
                  3'b010: begin
                     phi_d = prod_u[63:32]; plo_d = prod_u[31:0];
                     skip_d = 1'b0; cnt_d = MULT_N; state_d = BUSY;
                  end
                  3'b011: begin
                     phi_d = $unsigned(rem_s); plo_d = $unsigned(quo_s);
                     skip_d = (md.b == 32'd0); cnt_d = DIV_N; state_d = BUSY;
                  end
                  3'b100: begin
                     phi_d = rem_u; plo_d = quo_u;
                     skip_d = (md.b == 32'd0); cnt_d = DIV_N; state_d = BUSY;
                  end
                  3'b101: hi_d = md.a;
                  3'b110: lo_d = md.a;
                  default: ;
               endcase
            end
         end
         BUSY: begin
            // Any start seen here is dropped: no restart, no HI/LO write.
            if (cnt_q == CW'(1)) begin
               if (!skip_q) begin
                  hi_d = phi_q;
                  lo_d = plo_q;
               end
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
         skip_q  <= skip_d;
      end
   end

   assign busy       = (cnt_q != '0);
   assign md.busy    = busy;
   assign md.hi      = hi_q;
   assign md.lo      = lo_q;
   assign md.rd_data = md.rd_sel ? hi_q : lo_q;
   assign md.stall   = md.d_md_use &
                       (busy | (md.start & (md.op inside {3'b001, 3'b010, 3'b011, 3'b100})));
endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed vectors plus randomized ops against an arithmetic reference model.
module tb_mdu_ctrl;
   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mdu_ctrl_if md ();
   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .md(md));

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   // Reference: signed division done on magnitudes, signs applied afterwards.
   function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l);
      longint sa, sb, ma, mb, q, r;
      longint unsigned pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd1: begin q = sa * sb; h = q[63:32]; l = q[31:0]; end
         3'd2: begin pu = longint'(a) * longint'(b); h = pu[63:32]; l = pu[31:0]; end
         3'd3: if (b != 0) begin
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            q = ma / mb;
            r = ma % mb;
            if ((sa < 0) != (sb < 0)) q = -q;
            if (sa < 0) r = -r;
            h = r[31:0]; l = q[31:0];
         end
         3'd4: if (b != 0) begin h = a % b; l = a / b; end
         3'd5: h = a;
         3'd6: l = a;
         default: ;
      endcase
   endfunction

   function automatic int lat(input logic [2:0] op);
      return (op == 3'd1 || op == 3'd2) ? MC : (op == 3'd3 || op == 3'd4) ? DC : 0;
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      md.start = 1'b1; md.op = op; md.a = a; md.b = b;
      @(negedge clk);
      md.start = 1'b0; md.op = 3'd0;
   endtask

   task automatic test_reset();
      md.d_md_use = 1'b1;
      #1;
      n_cmp++; if (md.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", md.busy); end
      n_cmp++; if (md.hi !== 32'd0 || md.lo !== 32'd0) begin
         n_err++; $display("FAIL reset_hilo got %h/%h want 0/0", md.hi, md.lo); end
      n_cmp++; if (md.rd_data !== 32'd0) begin n_err++; $display("FAIL reset_rd got %h want 0", md.rd_data); end
      n_cmp++; if (md.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", md.stall); end
      md.d_md_use = 1'b0;
   endtask

   task automatic test_arith();
      logic [2:0]  t_op [6] = '{3'd5, 3'd6, 3'd4, 3'd1, 3'd2, 3'd3};
      logic [31:0] t_a  [6] = '{32'hA, 32'hB, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
      logic [31:0] t_b  [6] = '{32'h0, 32'h0, 32'h0, 32'h2, 32'h2, 32'h2};
      logic [31:0] t_h  [6] = '{32'hA, 32'hA, 32'hA, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF};
      logic [31:0] t_l  [6] = '{32'h0, 32'hB, 32'hB, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFD};
      for (int k = 0; k < 6; k++) begin
         issue(t_op[k], t_a[k], t_b[k]);
         for (int i = 0; i < lat(t_op[k]); i++) begin
            n_cmp++; if (md.busy !== 1'b1 || md.hi !== exp_hi || md.lo !== exp_lo) begin
               n_err++; $display("FAIL arith%0d_busy_c%0d got busy=%b hi=%h lo=%h want 1 %h %h",
                                 k, i, md.busy, md.hi, md.lo, exp_hi, exp_lo); end
            @(negedge clk);
         end
         exp_hi = t_h[k]; exp_lo = t_l[k];
         n_cmp++; if (md.busy !== 1'b0 || md.hi !== exp_hi || md.lo !== exp_lo) begin
            n_err++; $display("FAIL arith%0d_done got busy=%b hi=%h lo=%h want 0 %h %h",
                              k, md.busy, md.hi, md.lo, exp_hi, exp_lo); end
      end
   endtask

   task automatic test_stall_ignore();
      md.d_md_use = 1'b1;
      @(negedge clk);
      md.start = 1'b1; md.op = 3'd1; #1;
      n_cmp++; if (md.stall !== 1'b1) begin n_err++; $display("FAIL stall_issue got %b want 1", md.stall); end
      md.op = 3'd5; #1;
      n_cmp++; if (md.stall !== 1'b0) begin n_err++; $display("FAIL stall_mthi got %b want 0", md.stall); end
      md.start = 1'b0; md.op = 3'd0;
      issue(3'd1, 32'd3, 32'd4);
      for (int i = 0; i < MC; i++) begin
         n_cmp++; if (md.busy !== 1'b1 || md.stall !== 1'b1 || md.lo !== exp_lo) begin
            n_err++; $display("FAIL ignore_c%0d got busy=%b stall=%b lo=%h want 1 1 %h",
                              i, md.busy, md.stall, md.lo, exp_lo); end
         md.start = (i == 1 || i == 2);
         md.op = (i == 1) ? 3'd6 : 3'd1;
         md.a = (i == 1) ? 32'h55 : 32'h9;
         @(negedge clk);
      end
      md.start = 1'b0; md.op = 3'd0;
      exp_hi = 32'd0; exp_lo = 32'd12;
      n_cmp++; if (md.busy !== 1'b0 || md.stall !== 1'b0 || md.hi !== exp_hi || md.lo !== exp_lo) begin
         n_err++; $display("FAIL ignore_done got busy=%b stall=%b hi=%h lo=%h want 0 0 %h %h",
                           md.busy, md.stall, md.hi, md.lo, exp_hi, exp_lo); end
      issue(3'd5, 32'h77, 32'd0);
      exp_hi = 32'h77;
      n_cmp++; if (md.busy !== 1'b0 || md.hi !== exp_hi) begin
         n_err++; $display("FAIL mthi_idle got busy=%b hi=%h want 0 %h", md.busy, md.hi, exp_hi); end
      md.d_md_use = 1'b0;
   endtask

   task automatic test_mid_reset();
      issue(3'd3, 32'd100, 32'd7);
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      reset = 1'b1; #1;
      n_cmp++; if (md.busy !== 1'b0 || md.hi !== 32'd0 || md.lo !== 32'd0) begin
         n_err++; $display("FAIL midreset_async got busy=%b hi=%h lo=%h want 0 0 0", md.busy, md.hi, md.lo); end
      @(negedge clk); reset = 1'b0;
      exp_hi = 32'd0; exp_lo = 32'd0;
      repeat (DC + 2) @(negedge clk);
      n_cmp++; if (md.busy !== 1'b0 || md.hi !== 32'd0 || md.lo !== 32'd0) begin
         n_err++; $display("FAIL midreset_nocommit got busy=%b hi=%h lo=%h want 0 0 0", md.busy, md.hi, md.lo); end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b, h, l;
      for (int k = 0; k < 30; k++) begin
         op = 3'($urandom_range(1, 6));
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if (op == 3'd3 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
         issue(op, a, b);
         if (lat(op) == 0) ref_op(op, a, b, exp_hi, exp_lo);
         for (int i = 0; i < lat(op); i++) begin
            md.d_md_use = 1'($urandom); md.rd_sel = 1'($urandom); #1;
            n_cmp++; if (md.busy !== 1'b1 || md.stall !== md.d_md_use ||
                         md.rd_data !== (md.rd_sel ? exp_hi : exp_lo)) begin
               n_err++; $display("FAIL rand%0d_c%0d op=%0d got busy=%b stall=%b rd=%h want 1 %b %h",
                                 k, i, op, md.busy, md.stall, md.rd_data, md.d_md_use,
                                 md.rd_sel ? exp_hi : exp_lo); end
            @(negedge clk);
         end
         h = exp_hi; l = exp_lo;
         if (lat(op) != 0) ref_op(op, a, b, h, l);
         exp_hi = h; exp_lo = l;
         md.d_md_use = 1'b1; #1;
         n_cmp++; if (md.busy !== 1'b0 || md.stall !== 1'b0 || md.hi !== exp_hi || md.lo !== exp_lo) begin
            n_err++; $display("FAIL rand%0d_done op=%0d a=%h b=%h got busy=%b stall=%b hi=%h lo=%h want 0 0 %h %h",
                              k, op, a, b, md.busy, md.stall, md.hi, md.lo, exp_hi, exp_lo); end
         md.d_md_use = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      md.start = 1'b0; md.op = 3'd0; md.a = 32'd0; md.b = 32'd0;
      md.d_md_use = 1'b0; md.rd_sel = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b0;
      test_arith();
      test_stall_ignore();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
